// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and constants for the UART receive controller: capture FSM
// encodings, default sizing, and the oversample ratio used to pick a divisor.
package uart_rx_ctrl_pkg;

  typedef enum logic {
    RXC_IDLE = 1'b0,
    RXC_CLR  = 1'b1
  } rxc_state_e;

  localparam int DEF_DIV_W      = 16;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int OVERSAMPLE     = 16;

  // Terminal count for cfg_div: one clken every OVERSAMPLE-th of a bit period.
  function automatic int unsigned div_for_baud(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / (baud * OVERSAMPLE) - 1;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Byte stream (valid/ready) between the receive controller and its consumer.
interface uart_rx_ctrl_if;
  logic       valid;
  logic [7:0] data;
  logic       ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through sync FIFO; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter  int DEPTH = 8,
  parameter  int W     = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic [CW-1:0] o_count,
  output logic         o_full,
  output logic         o_empty
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Drives one uart_receiver: oversample tick generation, byte capture with
// rdy_clr handshake, and buffering into a FIFO presented as a valid/ready stream.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter  int DIV_W      = DEF_DIV_W,
  parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_cfg_en,
  input  logic [DIV_W-1:0] i_cfg_div,
  input  logic             i_rx_rdy,
  input  logic [7:0]       i_rx_data,
  output logic             o_rx_clken,
  output logic             o_rx_rdy_clr,
  output logic             o_rx_rst,
  uart_rx_ctrl_if.master   m_if,
  output logic [CW-1:0]    o_fifo_count,
  output logic             o_overrun,
  input  logic             i_ovr_clr
);

  rxc_state_e       r_state, w_state_nxt;
  logic [DIV_W-1:0] r_cnt;
  logic             r_pend, r_clken, r_rx_rst, r_ovr;
  logic             w_cap, w_wrap, w_fire, w_defer;
  logic             w_full, w_empty, w_pop, w_push, w_drop;

  // Capture FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RXC_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 1'b0;
    case (r_state)
      RXC_IDLE: if (i_rx_rdy && i_cfg_en) begin
        w_cap       = 1'b1;
        w_state_nxt = RXC_CLR;
      end
      RXC_CLR:  w_state_nxt = RXC_IDLE;
      default:  w_state_nxt = RXC_IDLE;
    endcase
    if (!i_cfg_en) w_state_nxt = RXC_IDLE;
  end

  assign o_rx_rdy_clr = (r_state == RXC_CLR);

  // Tick generation. The receiver lets rdy_clr override clken, so a tick that
  // would land on a CLR cycle is held in r_pend and issued one cycle later.
  assign w_wrap  = (r_cnt >= i_cfg_div);
  assign w_fire  = i_cfg_en & (w_wrap | r_pend);
  assign w_defer = (w_state_nxt == RXC_CLR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_pend   <= 1'b0;
      r_clken  <= 1'b0;
      r_rx_rst <= 1'b1;
    end else begin
      r_rx_rst <= ~i_cfg_en;
      if (!i_cfg_en) begin
        r_cnt   <= '0;
        r_pend  <= 1'b0;
        r_clken <= 1'b0;
      end else begin
        r_cnt   <= w_wrap ? '0 : r_cnt + 1'b1;
        r_clken <= w_fire & ~w_defer;
        r_pend  <= w_fire & w_defer;
      end
    end
  end

  assign o_rx_clken = r_clken;
  assign o_rx_rst   = r_rx_rst;

  // Byte buffering and overrun
  assign w_pop  = m_if.valid & m_if.ready;
  assign w_push = w_cap & (~w_full | w_pop);
  assign w_drop = w_cap & w_full & ~w_pop;

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (i_rx_data),
    .i_pop   (w_pop),
    .o_data  (m_if.data),
    .o_count (o_fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign m_if.valid = ~w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_ovr <= 1'b0;
    else if (w_drop)    r_ovr <= 1'b1;
    else if (i_ovr_clr) r_ovr <= 1'b0;
  end

  assign o_overrun = r_ovr;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: tick timing, capture handshake, FIFO
// order/overrun, full-with-pop, tick deferral around rdy_clr, async reset.
module tb_uart_rx_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_en;
  logic [15:0] cfg_div;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        rx_clken, rx_rdy_clr, rx_rst;
  logic [3:0]  fifo_count;
  logic        overrun, ovr_clr;
  int          n_vec = 0;
  int          n_err = 0;

  uart_rx_ctrl_if s_if();

  uart_rx_ctrl #(.DIV_W(16), .FIFO_DEPTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cfg_en     (cfg_en),
    .i_cfg_div    (cfg_div),
    .i_rx_rdy     (rx_rdy),
    .i_rx_data    (rx_data),
    .o_rx_clken   (rx_clken),
    .o_rx_rdy_clr (rx_rdy_clr),
    .o_rx_rst     (rx_rst),
    .m_if         (s_if),
    .o_fifo_count (fifo_count),
    .o_overrun    (overrun),
    .i_ovr_clr    (ovr_clr)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one byte as the receiver would; rdy stays high through CLR.
  task automatic send_byte(input logic [7:0] b);
    rx_rdy = 1'b1; rx_data = b;
    cyc();
    n_vec++;
    if (rx_rdy_clr !== 1'b1) begin n_err++; $display("FAIL rdy_clr_pulse byte %h: got %b want 1", b, rx_rdy_clr); end
    cyc();
    rx_rdy = 1'b0;
    n_vec++;
    if (rx_rdy_clr !== 1'b0) begin n_err++; $display("FAIL rdy_clr_single byte %h: got %b want 0", b, rx_rdy_clr); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_en = 1'b0; cfg_div = 16'd3; rx_rdy = 1'b0; rx_data = 8'h00;
    s_if.ready = 1'b0; ovr_clr = 1'b0;
    cyc(); cyc();
    n_vec++;
    if ({rx_clken, rx_rdy_clr, rx_rst, s_if.valid, s_if.data, fifo_count, overrun} !== {1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: got clken=%b clr=%b rst=%b v=%b d=%h cnt=%0d ovr=%b", rx_clken, rx_rdy_clr, rx_rst, s_if.valid, s_if.data, fifo_count, overrun);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_tick();
    cfg_en = 1'b0; cfg_div = 16'd3;
    cyc();
    cfg_en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      n_vec++;
      if (rx_clken !== ((i % 4) == 0)) begin n_err++; $display("FAIL tick_div3 cyc %0d: got %b want %b", i, rx_clken, (i % 4) == 0); end
      if (i == 1) begin
        n_vec++;
        if (rx_rst !== 1'b0) begin n_err++; $display("FAIL rx_rst_release: got %b want 0", rx_rst); end
      end
    end
  endtask

  task automatic test_capture();
    send_byte(8'hA5);
    n_vec++;
    if ({s_if.valid, s_if.data, fifo_count} !== {1'b1, 8'hA5, 4'd1}) begin
      n_err++; $display("FAIL capture_a5: got v=%b d=%h cnt=%0d want 1 a5 1", s_if.valid, s_if.data, fifo_count);
    end
    s_if.ready = 1'b1;
    cyc();
    s_if.ready = 1'b0;
    n_vec++;
    if ({s_if.valid, fifo_count} !== {1'b0, 4'd0}) begin
      n_err++; $display("FAIL pop_a5: got v=%b cnt=%0d want 0 0", s_if.valid, fifo_count);
    end
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    send_byte(8'h09);
    n_vec++;
    if ({overrun, fifo_count, s_if.data} !== {1'b1, 4'd8, 8'h01}) begin
      n_err++; $display("FAIL overrun_set: got ovr=%b cnt=%0d head=%h want 1 8 01", overrun, fifo_count, s_if.data);
    end
    s_if.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      n_vec++;
      if ({s_if.valid, s_if.data} !== {1'b1, 8'(i)}) begin
        n_err++; $display("FAIL drain_order %0d: got v=%b d=%h want 1 %h", i, s_if.valid, s_if.data, 8'(i));
      end
      cyc();
    end
    s_if.ready = 1'b0;
    n_vec++;
    if ({s_if.valid, overrun} !== {1'b0, 1'b1}) begin
      n_err++; $display("FAIL drained_sticky: got v=%b ovr=%b want 0 1", s_if.valid, overrun);
    end
    ovr_clr = 1'b1;
    cyc();
    ovr_clr = 1'b0;
    n_vec++;
    if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clr: got %b want 0", overrun); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp [8];
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i));
    rx_rdy = 1'b1; rx_data = 8'h5A; s_if.ready = 1'b1;
    cyc();
    s_if.ready = 1'b0;
    n_vec++;
    if ({fifo_count, overrun, rx_rdy_clr} !== {4'd8, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL full_push_pop: got cnt=%0d ovr=%b clr=%b want 8 0 1", fifo_count, overrun, rx_rdy_clr);
    end
    cyc();
    rx_rdy = 1'b0;
    for (int i = 0; i < 7; i++) exp[i] = 8'h11 + 8'(i);
    exp[7] = 8'h5A;
    s_if.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if ({s_if.valid, s_if.data} !== {1'b1, exp[i]}) begin
        n_err++; $display("FAIL full_drain %0d: got v=%b d=%h want 1 %h", i, s_if.valid, s_if.data, exp[i]);
      end
      cyc();
    end
    s_if.ready = 1'b0;
  endtask

  task automatic test_tick_defer();
    int ticks = 0, deferred = 0, clash = 0;
    cfg_en = 1'b0; cfg_div = 16'd1;
    cyc();
    cfg_en = 1'b1; s_if.ready = 1'b1;
    for (int i = 1; i <= 1000; i++) begin
      rx_rdy  = ((i % 7) == 0) && (i < 990);
      rx_data = 8'(i);
      cyc();
      if (rx_clken) begin
        ticks++;
        if ((i % 2) == 1) deferred++;
      end
      if (rx_clken && rx_rdy_clr) clash++;
    end
    rx_rdy = 1'b0; s_if.ready = 1'b0;
    n_vec++;
    if (ticks != 500) begin n_err++; $display("FAIL tick_total: got %0d want 500", ticks); end
    n_vec++;
    if (clash != 0) begin n_err++; $display("FAIL clken_clr_overlap: got %0d want 0", clash); end
    n_vec++;
    if (deferred == 0) begin n_err++; $display("FAIL tick_deferred: got %0d want >0", deferred); end
  endtask

  task automatic test_async_reset();
    send_byte(8'h31);
    send_byte(8'h32);
    rx_rdy = 1'b1; rx_data = 8'h33;
    cyc();
    n_vec++;
    if ({fifo_count, rx_rdy_clr} !== {4'd3, 1'b1}) begin
      n_err++; $display("FAIL pre_reset: got cnt=%0d clr=%b want 3 1", fifo_count, rx_rdy_clr);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({rx_clken, rx_rdy_clr, rx_rst, s_if.valid, s_if.data, fifo_count, overrun} !== {1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset: got clken=%b clr=%b rst=%b v=%b d=%h cnt=%0d ovr=%b", rx_clken, rx_rdy_clr, rx_rst, s_if.valid, s_if.data, fifo_count, overrun);
    end
    rx_rdy = 1'b0;
    #2;
    rst_n = 1'b1;
    cyc();
    n_vec++;
    if ({rx_rst, fifo_count, s_if.valid} !== {1'b0, 4'd0, 1'b0}) begin
      n_err++; $display("FAIL post_reset: got rst=%b cnt=%0d v=%b want 0 0 0", rx_rst, fifo_count, s_if.valid);
    end
  endtask

  initial begin
    test_reset();
    test_tick();
    test_capture();
    test_overrun();
    test_full_push_pop();
    test_tick_defer();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
